// File: rtl/gate_pkg.sv
// Shared types for the gate direction decoder: FSM state encoding, sensor pair codes
// and the sensor pair that each passage state corresponds to.
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EN1        = 3'd1,
        EN2        = 3'd2,
        EN3        = 3'd3,
        EX1        = 3'd4,
        EX2        = 3'd5,
        EX3        = 3'd6,
        WAIT_CLEAR = 3'd7
    } gate_state_t;

    // Pair is {A, B}: A is the outer sensor, B the inner one.
    localparam logic [1:0] PAIR_NONE = 2'b00;
    localparam logic [1:0] PAIR_A    = 2'b10;
    localparam logic [1:0] PAIR_B    = 2'b01;
    localparam logic [1:0] PAIR_AB   = 2'b11;

    function automatic logic [1:0] state_pair(input gate_state_t s);
        logic [1:0] p;
        case (s)
            EN1:     p = PAIR_A;
            EN2:     p = PAIR_AB;
            EN3:     p = PAIR_B;
            EX1:     p = PAIR_B;
            EX2:     p = PAIR_AB;
            EX3:     p = PAIR_A;
            default: p = PAIR_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/gate_direction_decoder_debounce.sv
// sensor_debounce: two-flop synchroniser followed by a level debouncer that adopts
// the synchronised level only after it has differed for DEBOUNCE_CYCLES cycles.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    logic          clean_q;
    logic          clean_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count tops out one short of DEBOUNCE_CYCLES because the adopting cycle is the last one.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/gate_direction_decoder.sv
// Gate direction decoder: debounced A/B sensors feed a passage FSM emitting enter/exit/fault
// pulses. Defining GATE_TIMEOUT_EN adds a stall timeout that pulses abort.
module gate_direction_decoder
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       enter,
    output logic       exit,
    output logic       fault,
    output logic       abort,
    output logic       a_clean,
    output logic       b_clean,
    output logic [2:0] state_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    gate_state_t state_q;
    gate_state_t state_d;
    logic        enter_q, enter_d;
    logic        exit_q, exit_d;
    logic        fault_q, fault_d;
    logic        abort_q, abort_d;
    logic [1:0]  pair;
    logic [1:0]  diff;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (a_raw),
        .clean_o (a_clean)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (b_raw),
        .clean_o (b_clean)
    );

    assign pair = {a_clean, b_clean};
    // Each passage state implies the pair last seen, so no separate previous-pair register is needed.
    assign diff = pair ^ state_pair(state_q);

`ifdef GATE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic          in_passage;

    assign in_passage = (state_q != IDLE) && (state_q != WAIT_CLEAR);
`endif

    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        fault_d = 1'b0;
        abort_d = 1'b0;
`ifdef GATE_TIMEOUT_EN
        tmo_d   = '0;
`endif
        if (state_q == WAIT_CLEAR) begin
            if (pair == PAIR_NONE) begin
                state_d = IDLE;
            end
        end else if (diff == 2'b11) begin
            fault_d = 1'b1;
            state_d = (pair == PAIR_NONE) ? IDLE : WAIT_CLEAR;
        end else if (diff != 2'b00) begin
            case (state_q)
                IDLE: state_d = (pair == PAIR_A) ? EN1 : EX1;
                EN1:  state_d = (pair == PAIR_AB) ? EN2 : IDLE;
                EN2:  state_d = (pair == PAIR_B) ? EN3 : EN1;
                EN3: begin
                    if (pair == PAIR_NONE) begin
                        state_d = IDLE;
                        enter_d = 1'b1;
                    end else begin
                        state_d = EN2;
                    end
                end
                EX1:  state_d = (pair == PAIR_AB) ? EX2 : IDLE;
                EX2:  state_d = (pair == PAIR_A) ? EX3 : EX1;
                EX3: begin
                    if (pair == PAIR_NONE) begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                    end else begin
                        state_d = EX2;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef GATE_TIMEOUT_EN
        // Timeout only fires on a cycle with no other transition, keeping abort exclusive.
        if (in_passage && (state_d == state_q)) begin
            if (tmo_q == TMO_LAST) begin
                state_d = WAIT_CLEAR;
                abort_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            fault_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            fault_q <= fault_d;
            abort_q <= abort_d;
        end
    end

`ifdef GATE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign enter   = enter_q;
    assign exit    = exit_q;
    assign fault   = fault_q;
    assign abort   = abort_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_gate_direction_decoder.sv
// Bench for gate_direction_decoder: scenario tasks plus a random sensor walk checked
// against a signed-progress passage model.
module tb_gate_direction_decoder;
  import gate_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int STEP = 10;

  logic clk;
  logic reset;
  logic a_raw, b_raw;
  logic enter, exit, fault, abort;
  logic a_clean, b_clean;
  logic [2:0] state_o;

  int checks;
  int passes;

  // pulse monitor
  int n_enter, n_exit, n_fault, n_abort, n_excl;

  // model: progress along the passage (+ entry, - exit), wait-clear flag, last pair
  int m_pos;
  bit m_wait;
  logic [1:0] m_pair;
  int m_enter, m_exit, m_fault, m_abort;

  gate_direction_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_raw(a_raw),
    .b_raw(b_raw),
    .enter(enter),
    .exit(exit),
    .fault(fault),
    .abort(abort),
    .a_clean(a_clean),
    .b_clean(b_clean),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset) begin
      if (enter === 1'b1) n_enter++;
      if (exit === 1'b1) n_exit++;
      if (fault === 1'b1) n_fault++;
      if (abort === 1'b1) n_abort++;
      if ($countones({enter, exit, fault, abort}) > 1) n_excl++;
    end
  end

  function automatic logic [1:0] pos_pair(input int p);
    case (p)
      1, -3: return 2'b10;
      2, -2: return 2'b11;
      3, -1: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic gate_state_t model_state();
    if (m_wait) return WAIT_CLEAR;
    case (m_pos)
      1: return EN1;
      2: return EN2;
      3: return EN3;
      -1: return EX1;
      -2: return EX2;
      -3: return EX3;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_wait = 1'b0;
    m_pair = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] q);
    int sgn;
    if (q == m_pair) return;
    if (m_wait) begin
      if (q == 2'b00) begin
        m_wait = 1'b0;
        m_pos = 0;
      end
    end else if ($countones(q ^ m_pair) == 2) begin
      m_fault++;
      m_pos = 0;
      m_wait = (q != 2'b00);
    end else if (m_pos == 0) begin
      m_pos = (q == 2'b10) ? 1 : -1;
    end else begin
      sgn = (m_pos > 0) ? 1 : -1;
      if ((m_pos == 3 || m_pos == -3) && q == 2'b00) begin
        if (sgn > 0) m_enter++;
        else m_exit++;
        m_pos = 0;
      end else if ((m_pos != 3 && m_pos != -3) && q == pos_pair(m_pos + sgn)) begin
        m_pos = m_pos + sgn;
      end else begin
        m_pos = m_pos - sgn;
      end
    end
    m_pair = q;
  endtask

  // driver: apply a pair and hold it for one step
  task automatic step(input logic [1:0] q);
    a_raw = q[1];
    b_raw = q[0];
    model_step(q);
    repeat (STEP) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({enter, exit, fault, abort} !== 4'b0000)
      $display("FAIL reset_pulses: got %b want 0000", {enter, exit, fault, abort});
    else passes++;
    checks++;
    if ({a_clean, b_clean} !== 2'b00)
      $display("FAIL reset_clean: got %b want 00", {a_clean, b_clean});
    else passes++;
    checks++;
    if (state_o !== 3'(IDLE))
      $display("FAIL reset_state: got %0d want %0d", state_o, IDLE);
    else passes++;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_entry();
    int s_en, s_ex, lat, k;
    s_en = n_enter;
    s_ex = n_exit;
    step(2'b10);
    step(2'b11);
    step(2'b01);
    a_raw = 1'b0;
    b_raw = 1'b0;
    model_step(2'b00);
    lat = -1;
    for (k = 1; k <= STEP; k++) begin
      @(posedge clk);
      #1;
      if (enter === 1'b1 && lat < 0) lat = k - 1;
    end
    checks++;
    if (lat !== DEB + 2)
      $display("FAIL entry_latency: got %0d want %0d", lat, DEB + 2);
    else passes++;
    checks++;
    if (n_enter - s_en !== 1)
      $display("FAIL entry_count: got %0d want 1", n_enter - s_en);
    else passes++;
    checks++;
    if (n_exit - s_ex !== 0)
      $display("FAIL entry_no_exit: got %0d want 0", n_exit - s_ex);
    else passes++;
    checks++;
    if (state_o !== 3'(model_state()))
      $display("FAIL entry_state: got %0d want %0d", state_o, model_state());
    else passes++;
  endtask

  task automatic test_three_exits();
    int s_en, s_ex, e_ex;
    s_en = n_enter;
    s_ex = n_exit;
    e_ex = m_exit;
    for (int i = 0; i < 3; i++) begin
      step(2'b01);
      step(2'b11);
      step(2'b10);
      step(2'b00);
    end
    checks++;
    if (n_exit - s_ex !== m_exit - e_ex || m_exit - e_ex !== 3)
      $display("FAIL exit_count: got %0d want 3", n_exit - s_ex);
    else passes++;
    checks++;
    if (n_enter - s_en !== 0)
      $display("FAIL exit_no_enter: got %0d want 0", n_enter - s_en);
    else passes++;
  endtask

  task automatic test_back_out();
    int s_en, s_ex, s_f;
    s_en = n_enter;
    s_ex = n_exit;
    s_f = n_fault;
    step(2'b10);
    step(2'b11);
    checks++;
    if (state_o !== 3'(EN2))
      $display("FAIL backout_mid_state: got %0d want %0d", state_o, EN2);
    else passes++;
    step(2'b10);
    step(2'b00);
    checks++;
    if ((n_enter - s_en) + (n_exit - s_ex) + (n_fault - s_f) !== 0)
      $display("FAIL backout_pulses: got %0d want 0", (n_enter - s_en) + (n_exit - s_ex) + (n_fault - s_f));
    else passes++;
    checks++;
    if (state_o !== 3'(IDLE))
      $display("FAIL backout_state: got %0d want %0d", state_o, IDLE);
    else passes++;
    step(2'b10);
    step(2'b11);
    step(2'b01);
    step(2'b00);
    checks++;
    if (n_enter - s_en !== 1)
      $display("FAIL backout_then_entry: got %0d want 1", n_enter - s_en);
    else passes++;
  endtask

  task automatic test_glitch();
    logic seen_clean;
    bit moved;
    int s_total;
    s_total = n_enter + n_exit + n_fault + n_abort;
    seen_clean = 1'b0;
    moved = 1'b0;
    a_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (a_clean !== 1'b0) seen_clean = 1'b1;
      if (state_o !== 3'(IDLE)) moved = 1'b1;
    end
    checks++;
    if (seen_clean !== 1'b0)
      $display("FAIL glitch3_clean: got %b want 0", seen_clean);
    else passes++;
    checks++;
    if (moved)
      $display("FAIL glitch3_state: got moved want idle");
    else passes++;
    @(posedge clk);
    #1;
    a_raw = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (a_clean === 1'b1) seen_clean = 1'b1;
    end
    checks++;
    if (seen_clean !== 1'b1)
      $display("FAIL glitch4_clean: got %b want 1", seen_clean);
    else passes++;
    repeat (STEP) @(posedge clk);
    #1;
    checks++;
    if (n_enter + n_exit + n_fault + n_abort - s_total !== 0 || state_o !== 3'(IDLE))
      $display("FAIL glitch4_after: got pulses %0d state %0d want 0 and %0d",
               n_enter + n_exit + n_fault + n_abort - s_total, state_o, IDLE);
    else passes++;
  endtask

  task automatic test_illegal_jump();
    int s_f, s_en, s_ex;
    s_f = n_fault;
    s_en = n_enter;
    s_ex = n_exit;
    step(2'b11);
    checks++;
    if (n_fault - s_f !== 1)
      $display("FAIL illegal_fault: got %0d want 1", n_fault - s_f);
    else passes++;
    checks++;
    if (state_o !== 3'(model_state()) || model_state() != WAIT_CLEAR)
      $display("FAIL illegal_wait: got %0d want %0d", state_o, WAIT_CLEAR);
    else passes++;
    step(2'b00);
    checks++;
    if (state_o !== 3'(IDLE))
      $display("FAIL illegal_clear: got %0d want %0d", state_o, IDLE);
    else passes++;
    checks++;
    if ((n_enter - s_en) + (n_exit - s_ex) !== 0 || n_fault - s_f !== 1)
      $display("FAIL illegal_pulses: got en+ex %0d fault %0d want 0 and 1",
               (n_enter - s_en) + (n_exit - s_ex), n_fault - s_f);
    else passes++;
  endtask

  task automatic test_timeout();
    int s_ab;
    s_ab = n_abort;
    a_raw = 1'b1;
    b_raw = 1'b0;
    model_step(2'b10);
    repeat (30) @(posedge clk);
    #1;
`ifdef GATE_TIMEOUT_EN
    m_abort++;
    m_pos = 0;
    m_wait = 1'b1;
`endif
    checks++;
    if (n_abort - s_ab !== m_abort)
      $display("FAIL timeout_abort: got %0d want %0d", n_abort - s_ab, m_abort);
    else passes++;
    checks++;
    if (state_o !== 3'(model_state()))
      $display("FAIL timeout_state: got %0d want %0d", state_o, model_state());
    else passes++;
    step(2'b00);
    checks++;
    if (state_o !== 3'(IDLE))
      $display("FAIL timeout_recover: got %0d want %0d", state_o, IDLE);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int s_total, s_en;
    step(2'b10);
    step(2'b11);
    checks++;
    if (state_o !== 3'(EN2))
      $display("FAIL rstmid_pre: got %0d want %0d", state_o, EN2);
    else passes++;
    s_total = n_enter + n_exit + n_fault + n_abort;
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({enter, exit, fault, abort, a_clean, b_clean} !== 6'b0 || state_o !== 3'(IDLE))
      $display("FAIL rstmid_immediate: got outs %b state %0d want 000000 and %0d",
               {enter, exit, fault, abort, a_clean, b_clean}, state_o, IDLE);
    else passes++;
    a_raw = 1'b0;
    b_raw = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (STEP) @(posedge clk);
    #1;
    checks++;
    if (n_enter + n_exit + n_fault + n_abort - s_total !== 0 || state_o !== 3'(IDLE))
      $display("FAIL rstmid_after: got pulses %0d state %0d want 0 and %0d",
               n_enter + n_exit + n_fault + n_abort - s_total, state_o, IDLE);
    else passes++;
    s_en = n_enter;
    step(2'b10);
    step(2'b11);
    step(2'b01);
    step(2'b00);
    checks++;
    if (n_enter - s_en !== 1)
      $display("FAIL rstmid_entry: got %0d want 1", n_enter - s_en);
    else passes++;
  endtask

  task automatic test_random_walk();
    int s_en, s_ex, s_f, e_en, e_ex, e_f;
    logic [1:0] q;
    s_en = n_enter;
    s_ex = n_exit;
    s_f = n_fault;
    e_en = m_enter;
    e_ex = m_exit;
    e_f = m_fault;
    for (int i = 0; i < 60; i++) begin
      if (i == 59) begin
        q = 2'b00;
      end else begin
        // bias toward single-bit moves so full passages occur often
        if ($urandom_range(0, 3) == 0) q = 2'($urandom_range(0, 3));
        else q = m_pair ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01);
        if (q == m_pair) q = ~m_pair;
      end
      if (q != m_pair) begin
        step(q);
        checks++;
        if (state_o !== 3'(model_state()))
          $display("FAIL rand_state[%0d]: got %0d want %0d", i, state_o, model_state());
        else passes++;
      end
    end
    checks++;
    if (n_enter - s_en !== m_enter - e_en)
      $display("FAIL rand_enter: got %0d want %0d", n_enter - s_en, m_enter - e_en);
    else passes++;
    checks++;
    if (n_exit - s_ex !== m_exit - e_ex)
      $display("FAIL rand_exit: got %0d want %0d", n_exit - s_ex, m_exit - e_ex);
    else passes++;
    checks++;
    if (n_fault - s_f !== m_fault - e_f)
      $display("FAIL rand_fault: got %0d want %0d", n_fault - s_f, m_fault - e_f);
    else passes++;
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_excl !== 0)
      $display("FAIL exclusive: got %0d overlapping cycles want 0", n_excl);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    n_enter = 0;
    n_exit = 0;
    n_fault = 0;
    n_abort = 0;
    n_excl = 0;
    m_enter = 0;
    m_exit = 0;
    m_fault = 0;
    m_abort = 0;
    test_reset();
    test_single_entry();
    test_three_exits();
    test_back_out();
    test_glitch();
    test_illegal_jump();
    test_timeout();
    test_reset_mid();
    test_random_walk();
    test_exclusive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
